// File: rtl/iomem_gpio_bank.sv
// GPIO bank on the picosoc iomem bus: direction control, synchronised inputs,
// atomic set/clear, and edge interrupts with write-1-to-clear pending bits.
module iomem_gpio_bank #(
    parameter int unsigned GPIO_WIDTH  = 32,
    parameter logic [7:0]  BASE_ADDR   = 8'h03,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iomem_valid,
    output logic                  iomem_ready,
    input  logic [3:0]            iomem_wstrb,
    input  logic [31:0]           iomem_addr,
    input  logic [31:0]           iomem_wdata,
    output logic [31:0]           iomem_rdata,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam int unsigned W = GPIO_WIDTH;
    localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  prev_q, out_q, dir_q, rise_en_q, fall_en_q, pend_q;
    logic [W-1:0]  out_d, dir_d, rise_en_d, fall_en_d, pend_d;
    logic [W-1:0]  sync, rise, fall, events, wmask, wd, w1c;
    logic [31:0]   lane_mask, rd_val;
    logic [2:0]    arm_cnt_q, offs;
    logic          ready_q, irq_q, sel, wr, armed;
    logic [31:0]   rdata_q;
    logic          unused_addr;

    assign unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata};

    assign sync  = sync_q[SYNC_STAGES-1];
    assign rise  = sync & ~prev_q;
    assign fall  = ~sync & prev_q;
    // Edges are ignored until the synchroniser has flushed post-reset zeros.
    assign armed = (arm_cnt_q == ARM_DONE);

    assign sel  = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
    assign wr   = sel && (iomem_wstrb != 4'b0000);
    assign offs = iomem_addr[4:2];

    assign lane_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                        {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign wmask = lane_mask[W-1:0];
    assign wd    = iomem_wdata[W-1:0] & wmask;

    always_comb begin
        events = '0;
        if (armed) begin
            events = (rise & rise_en_q) | (fall & fall_en_q);
        end
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr) begin
            case (offs)
                3'd0: out_d     = (out_q & ~wmask) | wd;
                3'd2: dir_d     = (dir_q & ~wmask) | wd;
                3'd3: out_d     = out_q | wd;
                3'd4: out_d     = out_q & ~wd;
                3'd5: rise_en_d = (rise_en_q & ~wmask) | wd;
                3'd6: fall_en_d = (fall_en_q & ~wmask) | wd;
                3'd7: w1c       = wd;
                default: ;
            endcase
        end
        // A new event outranks a simultaneous clear of the same bit.
        pend_d = (pend_q & ~w1c) | events;
    end

    always_comb begin
        rd_val = '0;
        case (offs)
            3'd0: rd_val[W-1:0] = out_q;
            3'd1: rd_val[W-1:0] = sync;
            3'd2: rd_val[W-1:0] = dir_q;
            3'd5: rd_val[W-1:0] = rise_en_q;
            3'd6: rd_val[W-1:0] = fall_en_q;
            3'd7: rd_val[W-1:0] = pend_q;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            prev_q    <= '0;
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            irq_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            arm_cnt_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            prev_q    <= sync;
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            irq_q     <= |pend_q;
            ready_q   <= sel;
            if (sel) rdata_q <= rd_val;
            if (!armed) arm_cnt_q <= arm_cnt_q + 3'd1;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign gpio_out    = out_q;
    assign gpio_oe     = dir_q;
    assign irq         = irq_q;

endmodule
